// File: rtl/bin_reader_if.sv
// Downstream word stream from bin_reader: valid/ready handshake with an end-of-burst flag.
interface bin_reader_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;

  modport master (output out_valid, output out_data, output out_last, input out_ready);
  modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/bin_reader.sv
// Burst read engine in front of the bin manager BRAM port A: reads len words from base_addr
// and streams them out through a 4-entry FIFO. Define BIN_READER_CHECKSUM_EN for the XOR checksum.
module bin_reader #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic                  bram_we,
  input  logic [DATA_WIDTH-1:0] bram_dout,
  bin_reader_if.master          dn,
  output logic [DATA_WIDTH-1:0] checksum
);

  localparam logic [ADDR_WIDTH:0] LenOne = (ADDR_WIDTH + 1)'(1);

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] bram_addr_q;
  logic [ADDR_WIDTH:0]   remaining_q;
  logic                  inflight_q;
  logic                  inflight_last_q;

  // FIFO entries are {last, data}
  logic [DATA_WIDTH:0]   mem_q [4];
  logic [1:0]            wr_ptr_q, rd_ptr_q;
  logic [2:0]            cnt_q, cnt_d;

  logic                  start_acc;
  logic                  room;
  logic                  issue;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH:0]   head;

  assign start_acc = (state_q == StIdle) && start;
  // Room is judged on registered state only, so out_ready never reaches the BRAM address.
  assign room      = (cnt_q + {2'b00, inflight_q}) < 3'd4;
  assign push      = inflight_q;
  assign head      = mem_q[rd_ptr_q];
  assign pop       = dn.out_valid && dn.out_ready;

  assign dn.out_valid = (cnt_q != 3'd0);
  assign dn.out_data  = head[DATA_WIDTH-1:0];
  assign dn.out_last  = dn.out_valid && head[DATA_WIDTH];

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign bram_we   = 1'b0;
  assign bram_addr = issue ? addr_q : bram_addr_q;

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) state_d = (len == '0) ? StDone : StRead;
      end
      StRead: begin
        if (room) begin
          issue = 1'b1;
          if (remaining_q == LenOne) state_d = StDrain;
        end
      end
      StDrain: begin
        if (pop && head[DATA_WIDTH]) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 3'd1;
    else if (!push && pop) cnt_d = cnt_q - 3'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      addr_q          <= '0;
      bram_addr_q     <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      bram_addr_q     <= bram_addr;
      inflight_q      <= issue;
      inflight_last_q <= issue && (remaining_q == LenOne);
      if (start_acc) begin
        addr_q      <= base_addr;
        remaining_q <= len;
      end else if (issue) begin
        addr_q      <= addr_q + ADDR_WIDTH'(1);
        remaining_q <= remaining_q - LenOne;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {inflight_last_q, bram_dout};
        wr_ptr_q        <= wr_ptr_q + 2'd1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
      cnt_q <= cnt_d;
    end
  end

`ifdef BIN_READER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] cks_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         cks_q <= '0;
    else if (start_acc) cks_q <= '0;
    else if (pop)       cks_q <= cks_q ^ head[DATA_WIDTH-1:0];
  end

  assign checksum = cks_q;
`else
  assign checksum = '0;
`endif

endmodule
